// File: rtl/pll_reconfig_ctrl.sv
// PLL init / runtime-reconfiguration controller driving the Gowin MDRDO dynamic-config port.
// Holds the PLL in reset, streams a register profile in, optionally reads it back, then
// releases reset and qualifies lock. Handles host profile switches, lock loss and retries.
module pll_reconfig_ctrl #(
    parameter int unsigned NUM_PROFILES    = 4,
    parameter int unsigned NUM_REGS        = 8,
    parameter int unsigned DEFAULT_PROFILE = 0,
    parameter int unsigned RST_CYCLES      = 64,
    parameter int unsigned LOCK_TIMEOUT    = 200000,
    parameter int unsigned LOCK_STABLE     = 1024,
    parameter int unsigned MAX_RETRY       = 3,
    parameter bit          VERIFY          = 1'b1,
    localparam int unsigned PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
    input  logic                           mdclk,
    input  logic                           reset_n,
    input  logic [NUM_PROFILES*NUM_REGS*8-1:0] cfg_table,
    input  logic [PW-1:0]                  profile_sel,
    input  logic                           reconfig_req,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [1:0]                     retry_cnt,
    output logic [PW-1:0]                  active_profile,
    output logic                           pll_rst,
    input  logic                           pll_lock,
    output logic [1:0]                     md_opc,
    output logic                           md_ainc,
    output logic [7:0]                     md_wdi,
    input  logic [7:0]                     md_rdo,
    output logic                           lock
);

    localparam int unsigned CntMax = (LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES;
    localparam int unsigned CW = $clog2(CntMax + 1);
    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned IW = $clog2(NUM_REGS) + 1;
    localparam int unsigned BW = $clog2(NUM_PROFILES * NUM_REGS * 8);

    localparam logic [CW-1:0] RstLast  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TmoLast  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] StabLast = SW'(LOCK_STABLE - 1);
    localparam logic [IW-1:0] RegLast  = IW'(NUM_REGS - 1);
    localparam logic [PW:0]   NumProf  = (PW + 1)'(NUM_PROFILES);
    localparam logic [2:0]    MaxRetry = 3'(MAX_RETRY);

    localparam logic [1:0] OpNop  = 2'b00;
    localparam logic [1:0] OpWr   = 2'b01;
    localparam logic [1:0] OpRd   = 2'b10;
    localparam logic [1:0] OpAclr = 2'b11;

    typedef enum logic [3:0] {
        StHold, StAclr, StWrite, StVaclr, StRead, StRwait, StWaitLock, StStable, StLocked, StError
    } state_e;

    state_e          r_state, w_state_d;
    logic [CW-1:0]   r_cnt, w_cnt_d;       // HOLD length, then lock timeout
    logic [SW-1:0]   r_stab, w_stab_d;
    logic [IW-1:0]   r_idx, w_idx_d;
    logic            r_wait, w_wait_d;
    logic [1:0]      r_retry, w_retry_d;
    logic [PW-1:0]   r_prof, w_prof_d;
    logic            r_done;
    logic            r_sync1, r_sync2;
    logic            w_lock_sync;
    logic            w_fail;
    logic [2:0]      w_retry_inc;
    logic [BW-1:0]   w_bit_idx;
    logic [7:0]      w_byte;

    assign w_lock_sync = r_sync2;
    assign w_retry_inc = {1'b0, r_retry} + 3'd1;
    assign w_bit_idx   = BW'((int'(r_prof) * NUM_REGS + int'(r_idx)) * 8);
    assign w_byte      = cfg_table[w_bit_idx +: 8];

    // State and datapath registers, plus the two-flop lock synchroniser
    always_ff @(posedge mdclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StHold;
            r_cnt   <= '0;
            r_stab  <= '0;
            r_idx   <= '0;
            r_wait  <= 1'b0;
            r_retry <= '0;
            r_prof  <= PW'(DEFAULT_PROFILE);
            r_done  <= 1'b0;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_stab  <= w_stab_d;
            r_idx   <= w_idx_d;
            r_wait  <= w_wait_d;
            r_retry <= w_retry_d;
            r_prof  <= w_prof_d;
            r_done  <= (w_state_d == StLocked) && (r_state != StLocked);
            r_sync1 <= pll_lock;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state and counter update
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_stab_d  = r_stab;
        w_idx_d   = r_idx;
        w_wait_d  = r_wait;
        w_retry_d = r_retry;
        w_prof_d  = r_prof;
        w_fail    = 1'b0;
        unique case (r_state)
            StHold: begin
                if (r_cnt >= RstLast) begin
                    w_state_d = StAclr;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StAclr: begin
                w_state_d = StWrite;
                w_idx_d   = '0;
            end
            StWrite: begin
                if (r_idx == RegLast) begin
                    w_idx_d   = '0;
                    w_state_d = VERIFY ? StVaclr : StWaitLock;
                end else begin
                    w_idx_d = r_idx + 1'b1;
                end
            end
            StVaclr: w_state_d = StRead;
            StRead: begin
                w_state_d = StRwait;
                w_wait_d  = 1'b0;
            end
            StRwait: begin
                // Read data lands two cycles after the READ opcode
                if (!r_wait) begin
                    w_wait_d = 1'b1;
                end else if (md_rdo != w_byte) begin
                    w_fail = 1'b1;
                end else if (r_idx == RegLast) begin
                    w_idx_d   = '0;
                    w_state_d = StWaitLock;
                end else begin
                    w_idx_d   = r_idx + 1'b1;
                    w_state_d = StRead;
                end
            end
            StWaitLock: begin
                if (w_lock_sync) begin
                    w_state_d = StStable;
                    w_stab_d  = SW'(1);   // the detecting cycle counts as the first
                end else if (r_cnt >= TmoLast) begin
                    w_fail = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            StStable: begin
                if (!w_lock_sync) begin
                    w_state_d = StWaitLock;
                    w_stab_d  = '0;
                end else if (r_stab >= StabLast) begin
                    w_state_d = StLocked;
                    w_stab_d  = '0;
                    w_retry_d = '0;
                end else begin
                    w_stab_d = r_stab + 1'b1;
                end
            end
            StLocked: begin
                if (!reconfig_req && !w_lock_sync) begin
                    w_state_d = StHold;
                    w_cnt_d   = '0;
                end
            end
            StError: ;
            default: w_state_d = StHold;
        endcase

        // Host request beats a simultaneous lock loss
        if ((r_state == StLocked || r_state == StError) && reconfig_req) begin
            w_retry_d = '0;
            w_cnt_d   = '0;
            w_stab_d  = '0;
            w_idx_d   = '0;
            if ({1'b0, profile_sel} < NumProf) begin
                w_prof_d  = profile_sel;
                w_state_d = StHold;
            end else begin
                w_state_d = StError;
            end
        end

        if (w_fail) begin
            w_cnt_d   = '0;
            w_stab_d  = '0;
            w_idx_d   = '0;
            w_retry_d = (r_retry == 2'd3) ? r_retry : w_retry_inc[1:0];
            w_state_d = (w_retry_inc < MaxRetry) ? StHold : StError;
        end
    end

    // Output decode
    always_comb begin
        pll_rst = 1'b1;
        lock    = 1'b0;
        busy    = 1'b1;
        err     = 1'b0;
        md_opc  = OpNop;
        md_ainc = 1'b0;
        md_wdi  = 8'h00;
        unique case (r_state)
            StAclr, StVaclr: md_opc = OpAclr;
            StWrite: begin
                md_opc  = OpWr;
                md_ainc = 1'b1;
                md_wdi  = w_byte;
            end
            StRead: begin
                md_opc  = OpRd;
                md_ainc = 1'b1;
            end
            StWaitLock, StStable: pll_rst = 1'b0;
            StLocked: begin
                pll_rst = 1'b0;
                lock    = w_lock_sync;
                busy    = !w_lock_sync;   // lock loss is visible in the cycle it is seen
            end
            StError: begin
                busy = 1'b0;
                err  = 1'b1;
            end
            default: ;
        endcase
    end

    assign done           = r_done;
    assign retry_cnt      = r_retry;
    assign active_profile = r_prof;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl: a behavioural PLL/MDRDO model echoes written
// bytes, raises lock some cycles after reset release, and can corrupt or glitch on demand.
module tb_pll_reconfig_ctrl;

    localparam int unsigned NP  = 3;
    localparam int unsigned NR  = 8;
    localparam int unsigned RST = 16;
    localparam int unsigned TMO = 200;
    localparam int unsigned LS  = 32;
    localparam int unsigned MR  = 3;
    localparam int unsigned PW  = 2;

    logic              mdclk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NP*NR*8-1:0] cfg_table = '0;
    logic [PW-1:0]     profile_sel = '0;
    logic              reconfig_req = 1'b0;
    logic              busy, done, err, pll_rst, md_ainc, lock;
    logic              pll_lock = 1'b0;
    logic [1:0]        retry_cnt, md_opc;
    logic [PW-1:0]     active_profile;
    logic [7:0]        md_wdi;
    logic [7:0]        md_rdo = 8'h00;

    int n_checks = 0;
    int n_errors = 0;

    always #5 mdclk = ~mdclk;

    pll_reconfig_ctrl #(
        .NUM_PROFILES(NP), .NUM_REGS(NR), .DEFAULT_PROFILE(0), .RST_CYCLES(RST),
        .LOCK_TIMEOUT(TMO), .LOCK_STABLE(LS), .MAX_RETRY(MR), .VERIFY(1'b1)
    ) dut (
        .mdclk(mdclk), .reset_n(reset_n), .cfg_table(cfg_table), .profile_sel(profile_sel),
        .reconfig_req(reconfig_req), .busy(busy), .done(done), .err(err),
        .retry_cnt(retry_cnt), .active_profile(active_profile), .pll_rst(pll_rst),
        .pll_lock(pll_lock), .md_opc(md_opc), .md_ainc(md_ainc), .md_wdi(md_wdi),
        .md_rdo(md_rdo), .lock(lock)
    );

    // Reference profile contents
    logic [7:0] prof [NP][NR];

    // PLL + MDRDO port model
    logic [7:0] mem [64];
    int   addr = 0;
    logic [7:0] p1 = 8'h00;
    int   cyc = 0, rcnt = 0, last_rise = 0, rise_cnt = 0;
    bit   lock_en = 1'b1;
    int   lock_dly = 20;
    int   glitch_after = 0;
    int   corrupt_gen = 0, corrupt_done = 0;

    always @(posedge mdclk) begin
        cyc    <= cyc + 1;
        md_rdo <= p1;
        if (md_opc == 2'b11) begin
            addr <= 0;
        end else if (md_opc == 2'b01) begin
            mem[addr] <= md_wdi;
            if (md_ainc) addr <= addr + 1;
        end else if (md_opc == 2'b10) begin
            if (addr == 3 && corrupt_done != corrupt_gen) begin
                p1           <= ~mem[addr];
                corrupt_done <= corrupt_gen;
            end else begin
                p1 <= mem[addr];
            end
            if (md_ainc) addr <= addr + 1;
        end
        if (pll_rst) begin
            rcnt     <= 0;
            pll_lock <= 1'b0;
        end else begin
            rcnt <= rcnt + 1;
            if (lock_en && rcnt >= lock_dly &&
                !(glitch_after > 0 && rcnt == lock_dly + glitch_after)) begin
                if (!pll_lock) begin
                    last_rise <= cyc + 1;
                    rise_cnt  <= rise_cnt + 1;
                end
                pll_lock <= 1'b1;
            end else begin
                pll_lock <= 1'b0;
            end
        end
    end

    // Trace collected at negedges by the stimulus process
    logic [7:0] wr_q[$];
    int n_rd, n_aclr, n_done, first_op, steps, lock_cyc, max_retry;
    logic lock_prev = 1'b0;

    task automatic clr();
        wr_q.delete();
        n_rd = 0; n_aclr = 0; n_done = 0; first_op = -1; steps = 0; lock_cyc = -1;
        max_retry = 0;
    endtask

    task automatic step();
        @(negedge mdclk);
        steps++;
        if (md_opc != 2'b00 && first_op < 0) first_op = steps;
        if (md_opc == 2'b01) wr_q.push_back(md_wdi);
        if (md_opc == 2'b10) n_rd++;
        if (md_opc == 2'b11) n_aclr++;
        if (done) n_done++;
        if (lock && !lock_prev) lock_cyc = cyc;
        lock_prev = lock;
        if (int'(retry_cnt) > max_retry) max_retry = int'(retry_cnt);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        do begin
            step();
            k++;
        end while (busy && k < budget);
        chk({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic chk_writes(input string tag, input int p, input int exp_n);
        int mism = 0;
        chk({tag, "_nwr"}, wr_q.size(), exp_n);
        foreach (wr_q[i]) if (wr_q[i] !== prof[p][i % NR]) mism++;
        chk({tag, "_wdata"}, mism, 0);
    endtask

    task automatic request(input int p);
        profile_sel  = PW'(p);
        reconfig_req = 1'b1;
        step();
        reconfig_req = 1'b0;
    endtask

    initial begin
        int k;
        int r0;
        for (int p = 0; p < NP; p++)
            for (int r = 0; r < NR; r++) begin
                prof[p][r] = 8'($urandom);
                cfg_table[(p*NR + r)*8 +: 8] = prof[p][r];
            end
        clr();

        // Reset values
        repeat (3) step();
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_lock", lock, 0);
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_retry", retry_cnt, 0);
        chk("rst_opc", md_opc, 0);
        chk("rst_ainc", md_ainc, 0);
        chk("rst_wdi", md_wdi, 0);
        chk("rst_active", active_profile, 0);

        // Automatic bring-up with the default profile
        @(negedge mdclk);
        reset_n = 1'b1;
        clr();
        wait_idle("t1", 2000);
        step(); step();
        chk("t1_first_op", first_op, RST);
        chk_writes("t1", 0, NR);
        chk("t1_nrd", n_rd, NR);
        chk("t1_naclr", n_aclr, 2);
        chk("t1_lock", lock, 1);
        chk("t1_lock_delay", lock_cyc - last_rise, LS + 2);
        chk("t1_done_once", n_done, 1);
        chk("t1_pll_rst", pll_rst, 0);
        chk("t1_retry", retry_cnt, 0);

        // Lock loss in LOCKED: same-profile reload, no retry
        lock_en = 1'b0;
        k = 0;
        do begin step(); k++; end while (lock && k < 10);
        chk("t2_lock_fell", lock, 0);
        chk("t2_busy", busy, 1);
        step();
        chk("t2_pll_rst", pll_rst, 1);
        lock_en = 1'b1;
        clr();
        wait_idle("t2", 2000);
        chk_writes("t2", 0, NR);
        chk("t2_lock", lock, 1);
        chk("t2_retry", retry_cnt, 0);
        chk("t2_active", active_profile, 0);

        // Profile switch with a corrupted read-back on the first pass
        clr();
        corrupt_gen++;
        request(1);
        chk("t3_lock_drop", lock, 0);
        chk("t3_active", active_profile, 1);
        wait_idle("t3", 2000);
        chk("t3_max_retry", max_retry, 1);
        chk("t3_retry_end", retry_cnt, 0);
        chk("t3_naclr", n_aclr, 4);
        chk("t3_nrd", n_rd, NR + 4);
        chk_writes("t3", 1, 2 * NR);
        chk("t3_lock", lock, 1);
        chk("t3_done", n_done, 1);

        // One-cycle lock glitch while qualifying
        r0 = rise_cnt;
        glitch_after = 10;
        clr();
        request(2);
        wait_idle("t4", 2000);
        glitch_after = 0;
        chk("t4_rises", rise_cnt - r0, 2);
        chk("t4_lock_delay", lock_cyc - last_rise, LS + 2);
        chk_writes("t4", 2, NR);
        chk("t4_active", active_profile, 2);

        // Out-of-range profile is rejected
        clr();
        request(3);
        chk("t5_err", err, 1);
        chk("t5_busy", busy, 0);
        chk("t5_lock", lock, 0);
        chk("t5_pll_rst", pll_rst, 1);
        chk("t5_active", active_profile, 2);

        // No lock at all: retries exhaust into ERROR
        lock_en = 1'b0;
        clr();
        request(1);
        chk("t6_err_clr", err, 0);
        chk("t6_busy", busy, 1);
        wait_idle("t6", 3000);
        chk("t6_err", err, 1);
        chk("t6_retry", retry_cnt, 3);
        chk("t6_pll_rst", pll_rst, 1);
        chk("t6_naclr", n_aclr, 2 * MR);
        chk("t6_nrd", n_rd, MR * NR);
        chk("t6_active", active_profile, 1);

        // Request while busy is ignored; reset mid-write restarts from scratch
        lock_en = 1'b1;
        clr();
        request(2);
        repeat (3) step();
        profile_sel  = 2'd0;
        reconfig_req = 1'b1;
        step();
        reconfig_req = 1'b0;
        k = 0;
        while (wr_q.size() < 4 && k < 200) begin step(); k++; end
        chk("t7_reach", wr_q.size(), 4);
        @(posedge mdclk);
        #1;
        chk("t7_opc_wr", md_opc, 1);
        chk("t7_wdi4", md_wdi, prof[2][4]);
        chk("t7_active_kept", active_profile, 2);
        reset_n = 1'b0;
        #1;
        chk("t7_rst_opc", md_opc, 0);
        chk("t7_rst_pll_rst", pll_rst, 1);
        chk("t7_rst_lock", lock, 0);
        chk("t7_rst_busy", busy, 1);
        chk("t7_rst_active", active_profile, 0);
        @(negedge mdclk);
        reset_n = 1'b1;
        clr();
        wait_idle("t7", 2000);
        chk("t7_first_op", first_op, RST);
        chk_writes("t7", 0, NR);
        chk("t7_lock", lock, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
